mpei_test_ctrl: RTL

//  APB3 simulation/bring-up test controller for the MPEI RV core wrapper. Sequences core reset,

---
 rtl/mpei_test_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mpei_test_ctrl.sv
// APB3 bring-up test controller: core reset sequencing, firmware verdict register, heartbeat watchdog, signature channels.
// Latency: verdict outputs register one edge after the deciding write/expiry; APB reads combinational; no backpressure (pready tied 1).
module mpei_test_ctrl #(
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TMO_W          = 32,
    parameter int NSIG           = 4,
    parameter int APB_AW         = 12
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   psel_i,
    input  logic                   penable_i,
    input  logic                   pwrite_i,
    input  logic [APB_AW-1:0]      paddr_i,
    input  logic [31:0]            pwdata_i,
    output logic [31:0]            prdata_o,
    output logic                   pready_o,
    output logic                   pslverr_o,
    output logic                   core_rst_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic                   fail_o,
    output logic                   timeout_o,
    output logic [32*NSIG-1:0]     sig_o
);

    localparam int RCW = $clog2(RST_CYCLES + 1);
    localparam int WW  = APB_AW - 2;

    localparam logic [2:0] S_HOLD = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_PASS = 3'd2;
    localparam logic [2:0] S_FAIL = 3'd3;
    localparam logic [2:0] S_TMO  = 3'd4;

    logic [2:0]             state;
    logic [2:0]             state_nxt;
    logic [RCW-1:0]         rst_cnt;
    logic [TMO_W-1:0]       tmo_cnt;
    logic [NSIG-1:0][31:0]  sig;

    logic            access;
    logic            wr;
    logic [WW-1:0]   word;
    logic            hit_res;
    logic            hit_hb;
    logic            hit_info;
    logic [NSIG-1:0] sig_sel;
    logic            mapped;
    logic            wr_res;
    logic            wr_hb;
    logic            tmo_expire;
    logic            unused_addr_lsb;

    assign access          = psel_i & penable_i;
    assign wr              = access & pwrite_i;
    assign word            = paddr_i[APB_AW-1:2];
    assign unused_addr_lsb = ^paddr_i[1:0];

    always_comb begin
        hit_res  = (word == WW'(0));
        hit_hb   = (word == WW'(1));
        hit_info = (word == WW'(16));
        sig_sel  = '0;
        for (int k = 0; k < NSIG; k++) begin
            if (word == WW'(k + 2)) sig_sel[k] = 1'b1;
        end
        mapped = hit_res | hit_hb | hit_info | (|sig_sel);
    end

    assign wr_res     = wr & hit_res;
    assign wr_hb      = wr & hit_hb;
    assign tmo_expire = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        prdata_o = '0;
        if (access) begin
            if (hit_res)  prdata_o = {29'b0, state};
            if (hit_hb)   prdata_o = 32'(tmo_cnt);
            if (hit_info) prdata_o = {8'(NSIG), 24'(RST_CYCLES)};
            for (int k = 0; k < NSIG; k++) begin
                if (sig_sel[k]) prdata_o = sig[k];
            end
        end
    end

    assign pready_o  = 1'b1;
    assign pslverr_o = access & ~mapped;
    assign sig_o     = sig;

    // A firmware verdict beats a coincident expiry; a heartbeat rescues a coincident expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            S_HOLD: if (rst_cnt == RCW'(RST_CYCLES - 1)) state_nxt = S_RUN;
            S_RUN: begin
                if (wr_res && pwdata_i[1:0] == 2'b01)      state_nxt = S_PASS;
                else if (wr_res && pwdata_i[1:0] == 2'b10) state_nxt = S_FAIL;
                else if (tmo_expire && !wr_hb)             state_nxt = S_TMO;
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_HOLD;
            rst_cnt    <= '0;
            tmo_cnt    <= '0;
            sig        <= '0;
            core_rst_o <= 1'b1;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            fail_o     <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_HOLD && state_nxt == S_HOLD) rst_cnt <= rst_cnt + RCW'(1);
            if (state == S_RUN) tmo_cnt <= wr_hb ? '0 : tmo_cnt + TMO_W'(1);
            for (int k = 0; k < NSIG; k++) begin
                if (wr && sig_sel[k]) sig[k] <= {sig[k][30:0], sig[k][31]} ^ pwdata_i;
            end
            core_rst_o <= (state_nxt == S_HOLD);
            done_o     <= (state_nxt == S_PASS) || (state_nxt == S_FAIL) || (state_nxt == S_TMO);
            pass_o     <= (state_nxt == S_PASS);
            fail_o     <= (state_nxt == S_FAIL) || (state_nxt == S_TMO);
            timeout_o  <= (state_nxt == S_TMO);
        end
    end

endmodule
